moving_sum_pipe: RTL and testbench



---
 rtl/moving_sum_pkg.sv | 14 +
 rtl/moving_sum_pipe_window.sv | 23 ++
 rtl/moving_sum_pipe.sv | 59 +++++
 tb/tb_moving_sum_pipe.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/moving_sum_pkg.sv
// moving_sum_pkg: shared defaults and width derivations for the moving-sum block
package moving_sum_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_WIN = 4;
  function automatic int avg_sh(input int win);
    return $clog2(win);
  endfunction
  function automatic int sum_w(input int data_w, input int win);
    return data_w + $clog2(win);
  endfunction
  function automatic int cnt_w(input int win);
    return $clog2(win) + 1;
  endfunction
endpackage

// File: rtl/moving_sum_pipe_window.sv
// sample_window: WIN-deep sample shift register exposing the oldest entry
module sample_window
  import moving_sum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WIN = DEF_WIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] oldest
);
  logic [DATA_W-1:0] win [WIN];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < WIN; i++) win[i] <= '0;
    end else if (en) begin
      win[0] <= din;
      for (int i = 1; i < WIN; i++) win[i] <= win[i-1];
    end
  assign oldest = win[WIN-1];
endmodule

// File: rtl/moving_sum_pipe.sv
// moving_sum_pipe: sliding-window sum/average with valid/ready and one output register
module moving_sum_pipe
  import moving_sum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WIN = DEF_WIN,
  localparam int SUM_W = sum_w(DATA_W, WIN),
  localparam int CNT_W = cnt_w(WIN),
  localparam int SH = avg_sh(WIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_avg,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  fill_cnt
);
  logic              acc;
  logic              full_next;
  logic [DATA_W-1:0] oldest;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_next;
  logic [CNT_W-1:0]  fill_next;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  // oldest is already part of sum, so the subtraction never underflows
  assign sum_next = sum + SUM_W'(in_data) - SUM_W'(oldest);
  assign fill_next = (fill_cnt == CNT_W'(WIN)) ? fill_cnt : fill_cnt + 1'b1;
  assign full_next = fill_next == CNT_W'(WIN);
  sample_window #(.DATA_W(DATA_W), .WIN(WIN)) u_win (
    .clk(clk),
    .rst(rst),
    .en(acc),
    .din(in_data),
    .oldest(oldest)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum <= '0;
      fill_cnt <= '0;
      out_sum <= '0;
      out_avg <= '0;
      out_valid <= 1'b0;
    end else if (acc) begin
      sum <= sum_next;
      fill_cnt <= fill_next;
      if (full_next) begin
        out_sum <= sum_next;
        out_avg <= sum_next[SUM_W-1:SH];
        out_valid <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_moving_sum_pipe.sv
// tb_moving_sum_pipe: scoreboard bench for moving_sum_pipe (DATA_W=8, WIN=4)
module tb_moving_sum_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_sum;
  logic [7:0] out_avg;
  logic       out_ready = 1'b1;
  logic [2:0] fill_cnt;
  int checks = 0;
  int errors = 0;
  int sb[$];
  int mw[4];
  int mcnt = 0;
  int xfers = 0;

  moving_sum_pipe dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_sum(out_sum),
    .out_avg(out_avg),
    .out_ready(out_ready),
    .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        xfers++;
        if (sb.size() == 0) chk("sb_unexpected_out", 1, 0);
        else begin
          int e;
          e = sb.pop_front();
          chk("sb_sum", 32'(out_sum), e);
          chk("sb_avg", 32'(out_avg), e / 4);
        end
      end
      if (in_valid && in_ready) begin
        int s;
        for (int i = 3; i > 0; i--) mw[i] = mw[i-1];
        mw[0] = int'(in_data);
        s = 0;
        for (int i = 0; i < 4; i++) s += mw[i];
        if (mcnt < 4) mcnt++;
        if (mcnt == 4) sb.push_back(s);
      end
    end
  end

  task automatic model_clear();
    sb.delete();
    for (int i = 0; i < 4; i++) mw[i] = 0;
    mcnt = 0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    model_clear();
    idle(2);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_fill_cnt", 32'(fill_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    idle(1);
    send(6); send(9); send(12);
    chk("prime_no_valid", 32'(out_valid), 0);
    chk("prime_fill", 32'(fill_cnt), 3);
    send(15);
    chk("first_valid", 32'(out_valid), 1);
    chk("first_sum", 32'(out_sum), 42);
    chk("first_avg", 32'(out_avg), 10);
    send(18);
    chk("second_valid", 32'(out_valid), 1);
    chk("second_sum", 32'(out_sum), 54);
    chk("second_avg", 32'(out_avg), 13);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd21;
    repeat (3) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_sum", 32'(out_sum), 54);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("release_sum", 32'(out_sum), 66);
    chk("release_avg", 32'(out_avg), 16);
    idle(2);
    reset_pulse();
    xfers = 0;
    for (int v = 1; v <= 5; v++) begin
      send(8'(v));
      idle(2);
    end
    chk("bubble_xfers", 32'(xfers), 2);
    reset_pulse();
    repeat (4) send(8'd255);
    chk("max_sum", 32'(out_sum), 1020);
    chk("max_avg", 32'(out_avg), 255);
    send(8'd0);
    chk("max_drop_sum", 32'(out_sum), 765);
    chk("max_drop_avg", 32'(out_avg), 191);
    out_ready = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_arst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    model_clear();
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_sum", 32'(out_sum), 0);
    chk("arst_fill_cnt", 32'(fill_cnt), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(6); send(9); send(12); send(15);
    chk("refill_sum", 32'(out_sum), 42);
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(0, 255)));
      chk("thru_valid", 32'(out_valid), 1);
    end
    idle(4);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
